// File: rtl/niosii_system_sysid_checker.sv
// Reads sysid word 0 (ID) and word 1 (timestamp), checks both, reports pass/fail/timeout.
// Optional: define SYSID_CHECK_AUTOSTART_EN to launch one sequence after each reset.
module niosii_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5896_920A,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [3:0]  retry_count,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    typedef enum logic [2:0] {
        IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, DONE
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  LAT_LAST = 2'(READ_LATENCY - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

    state_t      state, state_n;
    logic [15:0] tcnt;
    logic [1:0]  lat_cnt;
    logic        go;
    logic        accept, stall, tmo_hit, lat_last;
    logic        launch, retry, give_up, cap_id, cap_ts, check;

`ifdef SYSID_CHECK_AUTOSTART_EN
    logic auto_pend;

    always_ff @(posedge clock) begin
        if (reset) auto_pend <= 1'b1;
        else       auto_pend <= 1'b0;
    end

    assign go = start | auto_pend;
`else
    assign go = start;
`endif

    assign avm_read    = (state == RD_ID) || (state == RD_TS);
    assign avm_address = (state == RD_TS);
    assign busy        = (state != IDLE) && (state != DONE);
    assign done        = (state == DONE);

    assign accept   = avm_read & ~avm_waitrequest;
    assign stall    = avm_read & avm_waitrequest;
    assign tmo_hit  = stall && (tcnt >= TMO_LAST);
    assign lat_last = (lat_cnt == LAT_LAST);

    always_comb begin
        state_n = state;
        launch  = 1'b0;
        retry   = 1'b0;
        give_up = 1'b0;
        cap_id  = 1'b0;
        cap_ts  = 1'b0;
        check   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (go) begin
                    launch  = 1'b1;
                    state_n = RD_ID;
                end
            end
            RD_ID, RD_TS: begin
                if (accept) begin
                    if (READ_LATENCY == 0) begin
                        cap_id  = (state == RD_ID);
                        cap_ts  = (state == RD_TS);
                        state_n = (state == RD_ID) ? RD_TS : CHECK;
                    end else begin
                        state_n = (state == RD_ID) ? LAT_ID : LAT_TS;
                    end
                end else if (tmo_hit) begin
                    // A stall on either word restarts the whole sequence
                    if (retry_count < RETRY_MAX) begin
                        retry   = 1'b1;
                        state_n = RD_ID;
                    end else begin
                        give_up = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            LAT_ID: begin
                if (lat_last) begin
                    cap_id  = 1'b1;
                    state_n = RD_TS;
                end
            end
            LAT_TS: begin
                if (lat_last) begin
                    cap_ts  = 1'b1;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                check   = 1'b1;
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            tcnt        <= '0;
            lat_cnt     <= '0;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
            retry_count <= '0;
            captured_id <= '0;
            captured_ts <= '0;
        end else begin
            state <= state_n;

            if (state_n != state || retry)
                tcnt <= '0;
            else if (stall && tcnt != '1)
                tcnt <= tcnt + 16'd1;

            if (state_n != state)
                lat_cnt <= '0;
            else if (lat_cnt != '1)
                lat_cnt <= lat_cnt + 2'd1;

            if (launch) begin
                pass        <= 1'b0;
                id_mismatch <= 1'b0;
                ts_mismatch <= 1'b0;
                timeout     <= 1'b0;
                retry_count <= '0;
            end

            if (retry)
                retry_count <= retry_count + 4'd1;

            if (give_up) begin
                timeout     <= 1'b1;
                pass        <= 1'b0;
                id_mismatch <= 1'b0;
                ts_mismatch <= 1'b0;
            end

            if (cap_id) captured_id <= avm_readdata;
            if (cap_ts) captured_ts <= avm_readdata;

            if (check) begin
                id_mismatch <= (captured_id != EXPECTED_ID);
                ts_mismatch <= (captured_ts != EXPECTED_TIMESTAMP);
                pass        <= (captured_id == EXPECTED_ID) &&
                               (captured_ts == EXPECTED_TIMESTAMP);
            end
        end
    end

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Directed bench: one zero-latency checker (short timeout) and one READ_LATENCY=2 checker.
module tb_niosii_system_sysid_checker;

    localparam logic [31:0] TS = 32'h5896_920A;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_start, a_wait, a_addr, a_read, a_busy, a_done;
    logic        a_pass, a_idm, a_tsm, a_tmo;
    logic [3:0]  a_rc;
    logic [31:0] a_rdata, a_cid, a_cts;

    logic        b_start, b_addr, b_read, b_busy, b_done;
    logic        b_pass, b_idm, b_tsm, b_tmo;
    logic [3:0]  b_rc;
    logic [31:0] b_rdata, b_cid, b_cts;

    logic [31:0] s_id, s_ts;
    int unsigned s_wt;
    logic        s_stuck;
    int unsigned a_wcnt = 0;

    int errors = 0;
    int checks = 0;

    niosii_system_sysid_checker #(
        .READ_LATENCY(0), .TIMEOUT_CYCLES(8), .MAX_RETRIES(1)
    ) u_a (
        .clock(clk), .reset(rst), .start(a_start),
        .avm_address(a_addr), .avm_read(a_read),
        .avm_waitrequest(a_wait), .avm_readdata(a_rdata),
        .busy(a_busy), .done(a_done), .pass(a_pass),
        .id_mismatch(a_idm), .ts_mismatch(a_tsm), .timeout(a_tmo),
        .retry_count(a_rc), .captured_id(a_cid), .captured_ts(a_cts)
    );

    niosii_system_sysid_checker #(
        .READ_LATENCY(2)
    ) u_b (
        .clock(clk), .reset(rst), .start(b_start),
        .avm_address(b_addr), .avm_read(b_read),
        .avm_waitrequest(1'b0), .avm_readdata(b_rdata),
        .busy(b_busy), .done(b_done), .pass(b_pass),
        .id_mismatch(b_idm), .ts_mismatch(b_tsm), .timeout(b_tmo),
        .retry_count(b_rc), .captured_id(b_cid), .captured_ts(b_cts)
    );

    // Slave A: programmable stalls per read, combinational data
    assign a_wait  = s_stuck | (a_read && (a_wcnt < s_wt));
    assign a_rdata = a_addr ? s_ts : s_id;
    always @(posedge clk) begin
        if (a_read && a_wait) a_wcnt <= a_wcnt + 1;
        else                  a_wcnt <= 0;
    end

    // Slave B: data valid exactly two cycles after accept, garbage otherwise
    logic p1v = 1'b0, p1a = 1'b0, p2v = 1'b0, p2a = 1'b0;
    always @(posedge clk) begin
        p1v <= b_read;
        p1a <= b_addr;
        p2v <= p1v;
        p2a <= p1a;
    end
    assign b_rdata = p2v ? (p2a ? TS : 32'h0) : 32'hDEAD_BEEF;

    typedef struct {
        int unsigned wt;
        logic [31:0] id;
        logic [31:0] ts;
        int          cyc;
        logic        pass;
        logic        idm;
        logic        tsm;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; start is pulsed, and re-pulsed after edge re_at
    task automatic run_a(input int re_at, output int n, output int rd0,
                         output int bad);
        logic pst, pad;
        n = 0; rd0 = 0; bad = 0; pst = 1'b0; pad = 1'b0;
        a_start = 1'b1;
        while (n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            a_start = (n == re_at);
            if (pst && a_read && a_addr !== pad) bad++;
            if (a_read && !a_addr) rd0++;
            pst = a_read & a_wait;
            pad = a_addr;
            if (a_done) break;
        end
        a_start = 1'b0;
    endtask

    task automatic wait_both(input int lim);
        int k;
        k = 0;
        while (!(a_done && b_done) && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("wait_done_bound", 32'(a_done && b_done), 32'd1);
    endtask

    initial begin
        int n, rd0, bad, k;

        vecs[0] = '{0, 32'h0,         TS,            4,  1'b1, 1'b0, 1'b0};
        vecs[1] = '{0, 32'h0,         32'h5896_920B, 4,  1'b0, 1'b0, 1'b1};
        vecs[2] = '{3, 32'h0,         TS,            10, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{7, 32'h0,         TS,            18, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{0, 32'h0,         32'h0,         4,  1'b0, 1'b0, 1'b1};
        vecs[5] = '{1, 32'h1,         TS,            6,  1'b0, 1'b1, 1'b0};
        vecs[6] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4,  1'b0, 1'b1, 1'b1};

        rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
        s_id = 32'h0; s_ts = TS; s_wt = 0; s_stuck = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_read", 32'(a_read), 32'd0);
        chk("rst_addr", 32'(a_addr), 32'd0);
        chk("rst_rc", 32'(a_rc), 32'd0);
        chk("rst_cid", a_cid, 32'd0);
        chk("rst_cts", a_cts, 32'd0);
        chk("rst_pass", 32'(a_pass), 32'd0);
        rst = 1'b0;
`ifdef SYSID_CHECK_AUTOSTART_EN
        wait_both(40);
        chk("auto_pass_a", 32'(a_pass), 32'd1);
        chk("auto_pass_b", 32'(b_pass), 32'd1);
`endif
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            s_wt = vecs[i].wt; s_id = vecs[i].id; s_ts = vecs[i].ts;
            run_a(0, n, rd0, bad);
            chk($sformatf("v%0d_cycles", i), 32'(n), 32'(vecs[i].cyc));
            chk($sformatf("v%0d_pass", i), 32'(a_pass), 32'(vecs[i].pass));
            chk($sformatf("v%0d_idm", i), 32'(a_idm), 32'(vecs[i].idm));
            chk($sformatf("v%0d_tsm", i), 32'(a_tsm), 32'(vecs[i].tsm));
            chk($sformatf("v%0d_cid", i), a_cid, vecs[i].id);
            chk($sformatf("v%0d_cts", i), a_cts, vecs[i].ts);
            chk($sformatf("v%0d_tmo", i), 32'(a_tmo), 32'd0);
            chk($sformatf("v%0d_busy", i), 32'(a_busy), 32'd0);
            chk($sformatf("v%0d_addr_stable", i), 32'(bad), 32'd0);
            @(negedge clk);
        end

        s_wt = 0; s_id = 32'h0; s_ts = TS;
        run_a(0, n, rd0, bad);
        repeat (3) @(negedge clk);
        chk("hold_done", 32'(a_done), 32'd1);
        chk("hold_pass", 32'(a_pass), 32'd1);

        s_wt = 3;
        run_a(2, n, rd0, bad);
        chk("busy_start_cycles", 32'(n), 32'd10);
        chk("busy_start_pass", 32'(a_pass), 32'd1);

        s_wt = 0; s_stuck = 1'b1;
        run_a(0, n, rd0, bad);
        chk("tmo_cycles", 32'(n), 32'd17);
        chk("tmo_rd_id_cycles", 32'(rd0), 32'd16);
        chk("tmo_flag", 32'(a_tmo), 32'd1);
        chk("tmo_pass", 32'(a_pass), 32'd0);
        chk("tmo_rc", 32'(a_rc), 32'd1);
        chk("tmo_idm", 32'(a_idm), 32'd0);
        s_stuck = 1'b0;

        a_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_start = 1'b0;
        chk("restart_done", 32'(a_done), 32'd0);
        chk("restart_tmo", 32'(a_tmo), 32'd0);
        chk("restart_rc", 32'(a_rc), 32'd0);
        chk("restart_busy", 32'(a_busy), 32'd1);
        k = 0;
        while (!a_done && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("restart_pass", 32'(a_pass), 32'd1);

        s_id = 32'h1234;
        a_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrd_addr", 32'(a_addr), 32'd1);
        chk("midrd_cid", a_cid, 32'h1234);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_read", 32'(a_read), 32'd0);
        chk("midrst_addr", 32'(a_addr), 32'd0);
        chk("midrst_busy", 32'(a_busy), 32'd0);
        chk("midrst_done", 32'(a_done), 32'd0);
        chk("midrst_cid", a_cid, 32'd0);
        chk("midrst_cts", a_cts, 32'd0);
        s_id = 32'h0;
        rst = 1'b0;
`ifdef SYSID_CHECK_AUTOSTART_EN
        wait_both(40);
        chk("auto2_pass", 32'(a_pass), 32'd1);
`endif
        @(negedge clk);

        n = 0; rd0 = 0;
        b_start = 1'b1;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            b_start = 1'b0;
            if (b_read) rd0++;
            if (b_done) break;
        end
        chk("lat2_cycles", 32'(n), 32'd8);
        chk("lat2_read_cycles", 32'(rd0), 32'd2);
        chk("lat2_pass", 32'(b_pass), 32'd1);
        chk("lat2_cts", b_cts, TS);
        chk("lat2_cid", b_cid, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
